// File: rtl/csa_pipe_adder_if.sv
// Handshake and operand/result bundle for csa_pipe_adder.
// The ovf signal exists only when CSA_PIPE_OVF_EN is defined.
interface csa_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CSA_PIPE_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
`ifdef CSA_PIPE_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
`ifdef CSA_PIPE_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor: WIDTH/SEG stages, each SEG bits built from BLK-bit blocks.
// Define CSA_PIPE_OVF_EN to add the signed-overflow output (ovf) and pipeline the operand sign bits.
module csa_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int BLK   = 4
) (
    input logic             clk,
    input logic             rst_n,
    csa_pipe_adder_if.slave bus
);

    localparam int NSTG = WIDTH / SEG;
    localparam int NBLK = SEG / BLK;

    if ((WIDTH % SEG) != 0 || (SEG % BLK) != 0) begin : g_bad_params
        $error("csa_pipe_adder: WIDTH must be a multiple of SEG and SEG a multiple of BLK");
    end

    // One segment: ripple lowest block, higher blocks pick a precomputed sum by incoming carry.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           c);
        logic [SEG-1:0] s;
        logic           c_blk;
        logic [BLK:0]   r0;
        logic [BLK:0]   r1;
        s     = '0;
        c_blk = c;
        r0    = '0;
        r1    = '0;
        for (int i = 0; i < BLK; i++) begin
            s[i]  = x[i] ^ y[i] ^ c_blk;
            c_blk = (x[i] & y[i]) | (c_blk & (x[i] ^ y[i]));
        end
        for (int j = 1; j < NBLK; j++) begin
            r0 = {1'b0, x[j*BLK +: BLK]} + {1'b0, y[j*BLK +: BLK]};
            r1 = r0 + {{BLK{1'b0}}, 1'b1};
            s[j*BLK +: BLK] = c_blk ? r1[BLK-1:0] : r0[BLK-1:0];
            c_blk           = c_blk ? r1[BLK]     : r0[BLK];
        end
        return {c_blk, s};
    endfunction

    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  cy_q;
    logic [WIDTH-1:0] res_q   [NSTG];
    logic [WIDTH-1:0] a_q     [NSTG];
    logic [WIDTH-1:0] b_q     [NSTG];

    logic [NSTG-1:0]  load;
    logic [NSTG-1:0]  src_v;
    logic [NSTG-1:0]  src_c;
    logic [WIDTH-1:0] src_a   [NSTG];
    logic [WIDTH-1:0] src_b   [NSTG];
    logic [WIDTH-1:0] src_res [NSTG];
    logic [SEG:0]     seg_r   [NSTG];
    logic [WIDTH-1:0] nxt_res [NSTG];
    logic [WIDTH-1:0] nxt_a   [NSTG];
    logic [WIDTH-1:0] nxt_b   [NSTG];
    logic [NSTG-1:0]  nxt_cy;

`ifdef CSA_PIPE_OVF_EN
    logic [NSTG-1:0]  sa_q;
    logic [NSTG-1:0]  sb_q;
    logic [NSTG-1:0]  src_sa;
    logic [NSTG-1:0]  src_sb;
`endif

    // A stage may load if it or any later stage is empty (bubbles collapse), or the output drains.
    always_comb begin
        // NOTE: every combinational output is assigned on every pass, so no latch is inferred.
        for (int k = 0; k < NSTG; k++) begin
            load[k] = bus.out_ready;
            for (int j = k; j < NSTG; j++) begin
                if (!vld_q[j]) load[k] = 1'b1;
            end
        end
    end

    always_comb begin
        src_v[0]   = bus.in_valid;
        src_c[0]   = bus.sub | bus.cin;
        src_a[0]   = bus.a;
        src_b[0]   = bus.b ^ {WIDTH{bus.sub}};
        src_res[0] = '0;
`ifdef CSA_PIPE_OVF_EN
        src_sa[0]  = bus.a[WIDTH-1];
        src_sb[0]  = bus.b[WIDTH-1] ^ bus.sub;
`endif
        for (int k = 1; k < NSTG; k++) begin
            src_v[k]   = vld_q[k-1];
            src_c[k]   = cy_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_res[k] = res_q[k-1];
`ifdef CSA_PIPE_OVF_EN
            src_sa[k]  = sa_q[k-1];
            src_sb[k]  = sb_q[k-1];
`endif
        end
        for (int k = 0; k < NSTG; k++) begin
            seg_r[k]                    = seg_add(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
            nxt_res[k]                  = src_res[k];
            nxt_res[k][k*SEG +: SEG]    = seg_r[k][SEG-1:0];
            nxt_cy[k]                   = seg_r[k][SEG];
            // Keep only the operand bits later stages still have to resolve.
            nxt_a[k]                    = src_a[k] & ({WIDTH{1'b1}} << ((k + 1) * SEG));
            nxt_b[k]                    = src_b[k] & ({WIDTH{1'b1}} << ((k + 1) * SEG));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
`ifdef CSA_PIPE_OVF_EN
            sa_q  <= '0;
            sb_q  <= '0;
`endif
            for (int k = 0; k < NSTG; k++) begin
                res_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
            for (int k = 0; k < NSTG; k++) begin
                if (load[k]) begin
                    vld_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        res_q[k] <= nxt_res[k];
                        cy_q[k]  <= nxt_cy[k];
                        a_q[k]   <= nxt_a[k];
                        b_q[k]   <= nxt_b[k];
`ifdef CSA_PIPE_OVF_EN
                        sa_q[k]  <= src_sa[k];
                        sb_q[k]  <= src_sb[k];
`endif
                    end
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = vld_q[NSTG-1];
    assign bus.sum       = res_q[NSTG-1];
    assign bus.cout      = cy_q[NSTG-1];
`ifdef CSA_PIPE_OVF_EN
    assign bus.ovf       = (sa_q[NSTG-1] == sb_q[NSTG-1]) && (res_q[NSTG-1][WIDTH-1] != sa_q[NSTG-1]);
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed vectors plus a queue-based arithmetic model checked every cycle.
// Two instances: WIDTH=32/SEG=8/BLK=4 and WIDTH=16/SEG=16/BLK=4.
module tb_csa_pipe_adder;

  localparam int W     = 32;
  localparam int NSTG  = 4;
  localparam int W2    = 16;
  localparam int NSTG2 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_pipe_adder_if #(.WIDTH(W))  bus  ();
  csa_pipe_adder_if #(.WIDTH(W2)) bus2 ();

  csa_pipe_adder #(.WIDTH(W), .SEG(8), .BLK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  csa_pipe_adder #(.WIDTH(W2), .SEG(16), .BLK(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   last_lat;
  bit   rnd_on  = 1'b0;
  bit   rnd2_on = 1'b0;
  res_t q[$];
  res_t q2[$];
  res_t last;
  res_t last2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Plain modular arithmetic on a w-bit datapath.
  function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic c, input logic s);
    logic [63:0] mask;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [63:0] t;
    res_t        r;
    mask   = (64'd1 << w) - 64'd1;
    aa     = {32'd0, av} & mask;
    bb     = ({32'd0, bv} ^ (s ? mask : 64'd0)) & mask;
    t      = aa + bb + {63'd0, (s | c)};
    r.sum  = t[31:0] & mask[31:0];
    r.cout = t[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
    return r;
  endfunction

  // Compare process, main instance.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      last = '{default: '0};
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_sum", 64'(bus.sum), 64'd0);
      check("reset_cout", 64'(bus.cout), 64'd0);
`ifdef CSA_PIPE_OVF_EN
      check("reset_ovf", 64'(bus.ovf), 64'd0);
`endif
    end else begin
      check("in_ready_rule", 64'(bus.in_ready), 64'((q.size() < NSTG) || bus.out_ready));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", 64'(bus.out_valid), 64'd0);
        end else begin
          check("sum", 64'(bus.sum), 64'(q[0].sum));
          check("cout", 64'(bus.cout), 64'(q[0].cout));
`ifdef CSA_PIPE_OVF_EN
          check("ovf", 64'(bus.ovf), 64'(q[0].ovf));
`endif
          if (bus.out_ready) begin
            last = q.pop_front();
            n_out++;
          end
        end
      end else begin
        check("hold_sum", 64'(bus.sum), 64'(last.sum));
        check("hold_cout", 64'(bus.cout), 64'(last.cout));
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model(W, bus.a, bus.b, bus.cin, bus.sub));
    end
  end

  // Compare process, narrow single-stage instance.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q2.delete();
      last2 = '{default: '0};
      check("w16_reset_out_valid", 64'(bus2.out_valid), 64'd0);
    end else begin
      check("w16_in_ready_rule", 64'(bus2.in_ready), 64'((q2.size() < NSTG2) || bus2.out_ready));
      if (bus2.out_valid) begin
        if (q2.size() == 0) begin
          check("w16_unexpected_result", 64'(bus2.out_valid), 64'd0);
        end else begin
          check("w16_sum", 64'(bus2.sum), 64'(q2[0].sum));
          check("w16_cout", 64'(bus2.cout), 64'(q2[0].cout));
`ifdef CSA_PIPE_OVF_EN
          check("w16_ovf", 64'(bus2.ovf), 64'(q2[0].ovf));
`endif
          if (bus2.out_ready) last2 = q2.pop_front();
        end
      end else begin
        check("w16_hold_sum", 64'(bus2.sum), 64'(last2.sum));
      end
      if (bus2.in_valid && bus2.in_ready) q2.push_back(model(W2, {16'd0, bus2.a}, {16'd0, bus2.b}, bus2.cin, bus2.sub));
    end
  end

  // Random consumer backpressure while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_on)  bus.out_ready  = ($urandom_range(0, 3) != 0);
    if (rnd2_on) bus2.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
    bit acc = 1'b0;
    int n   = 0;
    bus.in_valid = 1'b1;
    bus.a = av; bus.b = bv; bus.cin = cv; bus.sub = sv;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    check("send_accepted", 64'(acc), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
    bit acc = 1'b0;
    int n   = 0;
    bus2.in_valid = 1'b1;
    bus2.a = av; bus2.b = bv; bus2.cin = cv; bus2.sub = sv;
    do begin
      @(negedge clk);
      acc = bus2.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    check("w16_send_accepted", 64'(acc), 64'd1);
    bus2.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [31:0] es, input logic ec, input logic eo);
    int n = 0;
    bus.out_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 100);
    last_lat = n;
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_sum"}, 64'(bus.sum), 64'(es));
    check({name, "_cout"}, 64'(bus.cout), 64'(ec));
`ifdef CSA_PIPE_OVF_EN
    check({name, "_ovf"}, 64'(bus.ovf), 64'(eo));
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation for %s", name);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    rnd_on = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   base;
    int   max_occ = 0;
    bit   saw_block = 1'b0;
    int   n;

    bus.in_valid  = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0; bus.sub  = 1'b0; bus.out_ready  = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0; bus2.out_ready = 1'b1;

    // Pin the model to a few hand-computed values.
    r = model(32, 32'd5, 32'd7, 1'b0, 1'b1);
    check("model_pin_sub_sum", 64'(r.sum), 64'hFFFF_FFFE);
    r = model(32, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    check("model_pin_ovf", 64'(r.ovf), 64'd1);
    r = model(16, 32'h0000_FFFF, 32'd1, 1'b0, 1'b0);
    check("model_pin_w16_cout", 64'({r.cout, r.sum[15:0]}), 64'h1_0000);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
    check("out_valid_after_reset", 64'(bus.out_valid), 64'd0);

    // Directed vectors with hand-computed results.
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    wait_out("t1", 32'h0000_0002, 1'b0, 1'b0);
    check("t1_latency", 64'(last_lat), 64'(NSTG));
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_out("t2", 32'h0000_0000, 1'b1, 1'b0);
    send(32'd5, 32'd7, 1'b0, 1'b1);
    wait_out("t3a", 32'hFFFF_FFFE, 1'b0, 1'b0);
    send(32'd7, 32'd5, 1'b1, 1'b1);
    wait_out("t3b", 32'h0000_0002, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_out("t4a", 32'h8000_0000, 1'b0, 1'b1);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
    wait_out("t4b", 32'h7FFF_FFFF, 1'b1, 1'b1);
    send(32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0);
    wait_out("t_mix", 32'h2222_2221, 1'b0, 1'b0);

    // Random operands under random backpressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 40; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    // Ten back-to-back ops with the consumer stalled for six cycles.
    base = n_out;
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send(32'(i) * 32'h0101_0101, 32'hF0F0_F0F0 + 32'(i), 1'(i % 2), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (!bus.in_ready) saw_block = 1'b1;
          if (q.size() > max_occ) max_occ = q.size();
        end
      end
    join
    drain();
    check("t5_in_ready_dropped", 64'(saw_block), 64'd1);
    check("t5_max_occupancy", 64'(max_occ), 64'(NSTG));
    check("t5_result_count", 64'(n_out - base), 64'd10);

    // Narrow single-stage instance.
    send2(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send2(16'd5, 16'd7, 1'b0, 1'b1);
    rnd2_on = 1'b1;
    for (int i = 0; i < 30; i++) send2(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rnd2_on = 1'b0;
    bus2.out_ready = 1'b1;
    n = 0;
    while (q2.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("w16_drain_empty", 64'(q2.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset with operations in flight and a result waiting at the output.
    bus.out_ready = 1'b0;
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    send(32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0);
    send(32'h0000_0050, 32'h0000_0060, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 50);
    check("t6_filled", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid_cleared", 64'(bus.out_valid), 64'd0);
    check("t6_sum_cleared", 64'(bus.sum), 64'd0);
    check("t6_cout_cleared", 64'(bus.cout), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    check("t6_in_ready_after_release", 64'(bus.in_ready), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("t6_no_stale", 64'(bus.out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
